// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: trims fetch groups and delivers in-order instructions to the Decoder.
// Optional IFQ_PERF_CNT_EN adds saturating full-stall and empty-cycle counters.
module instr_fetch_queue #(
  parameter int NUM_OF_FETCH = 4,
  parameter int IFQ_DEPTH    = 16,
  parameter int VADDR_WIDTH  = 39,
  parameter int PADDR_WIDTH  = 56
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [VADDR_WIDTH-1:0]              in_vaddr,
  input  logic [PADDR_WIDTH-1:0]              in_paddr,
  input  logic [32*NUM_OF_FETCH-1:0]          in_data,
  input  logic [NUM_OF_FETCH-1:0]             in_pred_taken,
  input  logic [NUM_OF_FETCH-1:0]             in_btb_hit,
  input  logic [NUM_OF_FETCH*VADDR_WIDTH-1:0] in_btb_addr,
  input  logic                                in_page_fault,
  input  logic                                in_access_fault,
  output logic [NUM_OF_FETCH-1:0]             out_valid,
  input  logic                                out_ready,
  output logic [NUM_OF_FETCH*VADDR_WIDTH-1:0] out_vaddr,
  output logic [NUM_OF_FETCH*PADDR_WIDTH-1:0] out_paddr,
  output logic [32*NUM_OF_FETCH-1:0]          out_data,
  output logic [NUM_OF_FETCH-1:0]             out_pred_taken,
  output logic [NUM_OF_FETCH-1:0]             out_btb_hit,
  output logic [NUM_OF_FETCH*VADDR_WIDTH-1:0] out_btb_addr,
  output logic [NUM_OF_FETCH-1:0]             out_page_fault,
  output logic [NUM_OF_FETCH-1:0]             out_access_fault
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]                         perf_full_stall_cnt,
  output logic [31:0]                         perf_empty_cnt
`endif
);

  localparam int LW    = $clog2(NUM_OF_FETCH);
  localparam int OFF_W = LW + 2;
  localparam int PTR_W = $clog2(IFQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [VADDR_WIDTH-1:0] vaddr_mem        [IFQ_DEPTH];
  logic [PADDR_WIDTH-1:0] paddr_mem        [IFQ_DEPTH];
  logic [31:0]            data_mem         [IFQ_DEPTH];
  logic                   pred_taken_mem   [IFQ_DEPTH];
  logic                   btb_hit_mem      [IFQ_DEPTH];
  logic [VADDR_WIDTH-1:0] btb_addr_mem     [IFQ_DEPTH];
  logic                   page_fault_mem   [IFQ_DEPTH];
  logic                   access_fault_mem [IFQ_DEPTH];

  logic                    fault;
  logic [LW-1:0]           start_lane;
  logic [LW-1:0]           end_lane;
  logic [NUM_OF_FETCH-1:0] keep;
  logic [CNT_W-1:0]        kept_cnt;
  logic [CNT_W-1:0]        deq_cnt;
  logic                    enq;
  logic                    deq;
  logic [PTR_W-1:0]        wr_idx     [NUM_OF_FETCH];
  logic [VADDR_WIDTH-1:0]  lane_vaddr [NUM_OF_FETCH];
  logic [PADDR_WIDTH-1:0]  lane_paddr [NUM_OF_FETCH];
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{in_vaddr[1:0], in_paddr[OFF_W-1:0]};

  assign fault      = in_page_fault | in_access_fault;
  assign start_lane = in_vaddr[OFF_W-1:2];

  // Descending scan so the lowest taken BTB hit at or after the start lane wins.
  always_comb begin
    end_lane = LW'(NUM_OF_FETCH - 1);
    for (int k = NUM_OF_FETCH - 1; k >= 0; k--) begin
      if ((LW'(k) >= start_lane) && in_pred_taken[k] && in_btb_hit[k]) begin
        end_lane = LW'(k);
      end
    end
    if (fault) begin
      end_lane = start_lane;
    end
  end

  assign kept_cnt = CNT_W'(end_lane - start_lane) + CNT_W'(1);
  assign in_ready = (CNT_W'(IFQ_DEPTH) - count_reg) >= CNT_W'(NUM_OF_FETCH);
  assign enq      = in_valid & in_ready & ~flush;
  assign deq      = out_ready & (count_reg != '0);
  assign deq_cnt  = (count_reg >= CNT_W'(NUM_OF_FETCH)) ? CNT_W'(NUM_OF_FETCH) : count_reg;

  // Kept lanes form a contiguous run starting at start_lane, so lane k lands at tail + (k - start).
  for (genvar gi = 0; gi < NUM_OF_FETCH; gi++) begin : g_lane
    localparam logic [LW-1:0] LANE = LW'(gi);
    assign keep[gi]       = (LANE >= start_lane) && (LANE <= end_lane);
    assign wr_idx[gi]     = tail_reg + PTR_W'(LANE - start_lane);
    assign lane_vaddr[gi] = {in_vaddr[VADDR_WIDTH-1:OFF_W], LANE, 2'b00};
    assign lane_paddr[gi] = {in_paddr[PADDR_WIDTH-1:OFF_W], LANE, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int k = 0; k < NUM_OF_FETCH; k++) begin
        if (keep[k]) begin
          vaddr_mem[wr_idx[k]]        <= lane_vaddr[k];
          paddr_mem[wr_idx[k]]        <= lane_paddr[k];
          data_mem[wr_idx[k]]         <= fault ? 32'd0 : in_data[32*k +: 32];
          pred_taken_mem[wr_idx[k]]   <= in_pred_taken[k];
          btb_hit_mem[wr_idx[k]]      <= in_btb_hit[k];
          btb_addr_mem[wr_idx[k]]     <= in_btb_addr[VADDR_WIDTH*k +: VADDR_WIDTH];
          page_fault_mem[wr_idx[k]]   <= in_page_fault;
          access_fault_mem[wr_idx[k]] <= in_access_fault;
        end
      end
    end
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (enq) tail_next = tail_reg + PTR_W'(kept_cnt);
      if (deq) head_next = head_reg + PTR_W'(deq_cnt);
      count_next = count_reg + (enq ? kept_cnt : '0) - (deq ? deq_cnt : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Invalid lanes are forced to zero so never-written storage cannot leak X.
  for (genvar gi = 0; gi < NUM_OF_FETCH; gi++) begin : g_out
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx          = head_reg + PTR_W'(gi);
    assign out_valid[gi]   = count_reg > CNT_W'(gi);
    assign out_vaddr[gi*VADDR_WIDTH +: VADDR_WIDTH]    = out_valid[gi] ? vaddr_mem[rd_idx] : '0;
    assign out_paddr[gi*PADDR_WIDTH +: PADDR_WIDTH]    = out_valid[gi] ? paddr_mem[rd_idx] : '0;
    assign out_data[gi*32 +: 32]                       = out_valid[gi] ? data_mem[rd_idx] : '0;
    assign out_pred_taken[gi]                          = out_valid[gi] & pred_taken_mem[rd_idx];
    assign out_btb_hit[gi]                             = out_valid[gi] & btb_hit_mem[rd_idx];
    assign out_btb_addr[gi*VADDR_WIDTH +: VADDR_WIDTH] = out_valid[gi] ? btb_addr_mem[rd_idx] : '0;
    assign out_page_fault[gi]                          = out_valid[gi] & page_fault_mem[rd_idx];
    assign out_access_fault[gi]                        = out_valid[gi] & access_fault_mem[rd_idx];
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_full_stall_cnt <= '0;
      perf_empty_cnt      <= '0;
    end else begin
      if (in_valid && !in_ready && (perf_full_stall_cnt != '1)) begin
        perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
      end
      if ((count_reg == '0) && !flush && (perf_empty_cnt != '1)) begin
        perf_empty_cnt <= perf_empty_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed scenarios plus random groups,
// checked against a lane-level queue model.
module tb_instr_fetch_queue;
  localparam int NF = 4;
  localparam int D  = 16;
  localparam int VW = 39;
  localparam int PW = 56;

  typedef struct packed {
    logic [VW-1:0] vaddr;
    logic [PW-1:0] paddr;
    logic [31:0]   data;
    logic          pt;
    logic          bh;
    logic [VW-1:0] ba;
    logic          pf;
    logic          af;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_ready;
  logic [VW-1:0]    in_vaddr;
  logic [PW-1:0]    in_paddr;
  logic [32*NF-1:0] in_data;
  logic [NF-1:0]    in_pred_taken, in_btb_hit;
  logic [NF*VW-1:0] in_btb_addr;
  logic             in_page_fault, in_access_fault;
  logic [NF-1:0]    out_valid, out_pred_taken, out_btb_hit, out_page_fault, out_access_fault;
  logic [NF*VW-1:0] out_vaddr, out_btb_addr;
  logic [NF*PW-1:0] out_paddr;
  logic [32*NF-1:0] out_data;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  instr_fetch_queue #(.NUM_OF_FETCH(NF), .IFQ_DEPTH(D), .VADDR_WIDTH(VW), .PADDR_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_vaddr(in_vaddr), .in_paddr(in_paddr), .in_data(in_data),
    .in_pred_taken(in_pred_taken), .in_btb_hit(in_btb_hit), .in_btb_addr(in_btb_addr),
    .in_page_fault(in_page_fault), .in_access_fault(in_access_fault),
    .out_valid(out_valid), .out_ready(out_ready), .out_vaddr(out_vaddr), .out_paddr(out_paddr),
    .out_data(out_data), .out_pred_taken(out_pred_taken), .out_btb_hit(out_btb_hit),
    .out_btb_addr(out_btb_addr), .out_page_fault(out_page_fault), .out_access_fault(out_access_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: keep lanes from the start lane up to the first taken hit; a fault keeps only the start lane.
  task automatic model_push();
    int   s;
    bit   fault;
    ent_t e;
    s     = int'(in_vaddr[3:2]);
    fault = in_page_fault || in_access_fault;
    for (int k = s; k < NF; k++) begin
      e.vaddr = (in_vaddr & ~VW'(15)) + VW'(4 * k);
      e.paddr = (in_paddr & ~PW'(15)) + PW'(4 * k);
      e.data  = fault ? 32'd0 : in_data[32*k +: 32];
      e.pt    = in_pred_taken[k];
      e.bh    = in_btb_hit[k];
      e.ba    = in_btb_addr[VW*k +: VW];
      e.pf    = in_page_fault;
      e.af    = in_access_fault;
      sb.push_back(e);
      if (fault || (in_pred_taken[k] && in_btb_hit[k])) break;
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(output bit acc);
    bit rdy;
    rdy = (D - sb.size()) >= NF;
    @(posedge clk);
    acc = in_valid && rdy && !flush;
    if (flush) sb.delete();
    else if (acc) model_push();
    #1;
  endtask

  task automatic set_group(input logic [VW-1:0] va, input logic [127:0] d,
                           input logic [3:0] pt, input logic [3:0] bh, input logic [VW-1:0] ba2,
                           input bit pf);
    in_vaddr        = va;
    in_paddr        = PW'(56'h80_0000_0000) | PW'(va);
    in_data         = d;
    in_pred_taken   = pt;
    in_btb_hit      = bh;
    in_btb_addr     = '0;
    in_btb_addr[VW*2 +: VW] = ba2;
    in_page_fault   = pf;
    in_access_fault = 1'b0;
  endtask

  task automatic rand_group();
    in_vaddr = VW'({$urandom(), $urandom()}) & ~VW'(3);
    in_paddr = PW'({$urandom(), $urandom()});
    for (int k = 0; k < NF; k++) begin
      in_data[32*k +: 32]     = $urandom();
      in_btb_addr[VW*k +: VW] = VW'({$urandom(), $urandom()});
    end
    in_pred_taken   = NF'($urandom() & $urandom());
    in_btb_hit      = NF'($urandom() & $urandom());
    in_page_fault   = ($urandom_range(0, 15) == 0);
    in_access_fault = ($urandom_range(0, 15) == 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    in_valid  = 1'b0;
    out_ready = rdy;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  // Monitor: compare presented lanes with the head of the scoreboard, pop on acceptance.
  int         m_n;
  logic [4:0] m_mask;
  ent_t       m_act;
  always @(negedge clk) begin
    if (mon_en) begin
      m_n    = (sb.size() < NF) ? sb.size() : NF;
      m_mask = (5'd1 << m_n) - 5'd1;
      chk("in_ready", 256'(in_ready), 256'((D - sb.size()) >= NF));
      chk("out_valid", 256'(out_valid), 256'(m_mask[NF-1:0]));
      for (int k = 0; k < m_n; k++) begin
        m_act.vaddr = out_vaddr[VW*k +: VW];
        m_act.paddr = out_paddr[PW*k +: PW];
        m_act.data  = out_data[32*k +: 32];
        m_act.pt    = out_pred_taken[k];
        m_act.bh    = out_btb_hit[k];
        m_act.ba    = out_btb_addr[VW*k +: VW];
        m_act.pf    = out_page_fault[k];
        m_act.af    = out_access_fault[k];
        chk($sformatf("lane%0d", k), 256'(m_act), 256'(sb[k]));
      end
      if (out_ready && !flush) begin
        for (int k = 0; k < m_n; k++) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int tries;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_group('0, '0, '0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_out_vaddr", 256'(out_vaddr), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Aligned group, no hits
    set_group(39'h1000, 128'hA3_000000A2_000000A1_000000A0, 4'b0000, 4'b0000, '0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b0; step(acc);
    idle(3, 1'b1);

    // Misaligned start with taken hit in lane 2
    set_group(39'h2008, 128'hB3_000000B2_000000B1_000000B0, 4'b0100, 4'b0100, 39'h3000, 1'b0);
    in_valid = 1'b1; step(acc);
    idle(2, 1'b1);

    // Page fault keeps only the start lane with zeroed data
    set_group(39'h4004, 128'hC3_000000C2_000000C1_000000C0, 4'b0000, 4'b0000, '0, 1'b1);
    in_valid = 1'b1; step(acc);
    idle(2, 1'b1);

    // Backpressure: fill, hold a 5th group, release one block
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_group(39'h5000 + 39'(16 * i), {4{$urandom()}}, 4'b0000, 4'b0000, '0, 1'b0);
      in_valid = 1'b1; step(acc);
    end
    out_ready = 1'b1; step(acc);
    out_ready = 1'b0; step(acc);
    idle(6, 1'b1);

    // Wrap-around with 3-lane groups and toggling out_ready
    for (int i = 0; i < 16; i++) begin
      set_group(39'h6004 + 39'(16 * i), {$urandom(), $urandom(), $urandom(), $urandom()},
                4'b0000, 4'b0000, '0, 1'b0);
      in_valid = 1'b1;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
        out_ready = ~out_ready;
        step(acc);
        tries++;
      end
      chk("wrap_accept", 256'(acc), 256'(1));
    end
    idle(8, 1'b1);

    // Flush with a simultaneous enqueue, then a fresh group
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_group(39'h7000 + 39'(16 * i), {4{$urandom()}}, 4'b0000, 4'b0000, '0, 1'b0);
      in_valid = 1'b1; step(acc);
    end
    set_group(39'h7100, {4{$urandom()}}, 4'b0000, 4'b0000, '0, 1'b0);
    flush = 1'b1; out_ready = 1'b1; step(acc);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; step(acc);
    set_group(39'h7200, {4{$urandom()}}, 4'b0000, 4'b0000, '0, 1'b0);
    in_valid = 1'b1; step(acc);
    idle(3, 1'b1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rand_group();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 31) == 0);
      step(acc);
    end
    flush = 1'b0;
    idle(10, 1'b1);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
